key_event_capture: RTL and testbench

- Input-side companion to the LED output driver. The MCU writes LED patterns through that driver; this block reads push-buttons back into the MCU.
- Synchronises and debounces NUM_KEYS raw button inputs and tracks a stable key state per key.
- Latches press/release events into sticky per-key flags that the MCU clears by write-1.
- Raises a level interrupt while any flag is pending and interrupts are enabled.

---
 rtl/key_event_capture.sv | 136 +++++++++++++
 tb/tb_key_event_capture.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_capture.sv
// Push-button reader: 2-flop sync, tick-paced debounce, sticky press/release flags, level IRQ.
// Define KEY_LONGPRESS_EN to add per-key long-press detection; otherwise long_evt is tied to 0.
module key_event_capture #(
    parameter int NUM_KEYS       = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int DB_SAMPLES     = 4,
    parameter int LONG_TICKS     = 200
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [31:0]         debounce_period,
    input  logic                irq_en,
    input  logic [NUM_KEYS-1:0] evt_clr,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_evt,
    output logic [NUM_KEYS-1:0] release_evt,
    output logic [NUM_KEYS-1:0] long_evt,
    output logic                irq
);
    localparam int            DW      = $clog2(DB_SAMPLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_SAMPLES - 1);
    localparam logic [NUM_KEYS-1:0] INVERT = {NUM_KEYS{KEY_ACTIVE_LOW}};

    logic [NUM_KEYS-1:0] sync1_reg;
    logic [NUM_KEYS-1:0] sync2_reg;
    logic [31:0]         tick_cnt_reg;
    logic                tick;
    logic [NUM_KEYS-1:0] state_vec;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] release_vec;
    logic [NUM_KEYS-1:0] long_vec;
    logic                irq_reg;

    // >= rather than == so a shrinking period never has to wrap the counter
    assign tick = (tick_cnt_reg >= debounce_period);

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            tick_cnt_reg <= '0;
        end else begin
            sync1_reg    <= key_in ^ INVERT;
            sync2_reg    <= sync1_reg;
            tick_cnt_reg <= tick ? 32'd0 : tick_cnt_reg + 32'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic [DW-1:0] db_cnt_reg;
            logic          state_reg;
            logic          press_reg;
            logic          release_reg;
            logic          accept;
            logic          press_set;
            logic          release_set;

            assign accept      = tick && (sync2_reg[gi] != state_reg) && (db_cnt_reg == DB_LAST);
            assign press_set   = accept && !state_reg;
            assign release_set = accept && state_reg;

            always_ff @(posedge clk) begin
                if (!RSTn) begin
                    db_cnt_reg  <= '0;
                    state_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    if (tick) begin
                        if (sync2_reg[gi] == state_reg) begin
                            db_cnt_reg <= '0;
                        end else if (db_cnt_reg == DB_LAST) begin
                            db_cnt_reg <= '0;
                            state_reg  <= ~state_reg;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + DW'(1);
                        end
                    end
                    // a set on the same edge as a clear must win
                    press_reg   <= (press_reg & ~evt_clr[gi]) | press_set;
                    release_reg <= (release_reg & ~evt_clr[gi]) | release_set;
                end
            end

            assign state_vec[gi]   = state_reg;
            assign press_vec[gi]   = press_reg;
            assign release_vec[gi] = release_reg;

`ifdef KEY_LONGPRESS_EN
            localparam int            LW        = $clog2(LONG_TICKS + 1);
            localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_TICKS - 1);
            logic [LW-1:0] hold_cnt_reg;
            logic          long_reg;
            logic          long_set;

            // saturating at LONG_TICKS guarantees a single long event per press
            assign long_set = tick && state_reg && (hold_cnt_reg == HOLD_LAST);

            always_ff @(posedge clk) begin
                if (!RSTn) begin
                    hold_cnt_reg <= '0;
                    long_reg     <= 1'b0;
                end else begin
                    if (!state_reg) begin
                        hold_cnt_reg <= '0;
                    end else if (tick && (hold_cnt_reg != LW'(LONG_TICKS))) begin
                        hold_cnt_reg <= hold_cnt_reg + LW'(1);
                    end
                    long_reg <= (long_reg & ~evt_clr[gi]) | long_set;
                end
            end

            assign long_vec[gi] = long_reg;
`else
            assign long_vec[gi] = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_en & (|(press_vec | release_vec | long_vec));
        end
    end

    assign key_state   = state_vec;
    assign press_evt   = press_vec;
    assign release_evt = release_vec;
    assign long_evt    = long_vec;
    assign irq         = irq_reg;

endmodule

// File: tb/tb_key_event_capture.sv
// Testbench for key_event_capture: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_key_event_capture;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int LT = 5;
`ifdef KEY_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [31:0]   debounce_period = 32'd0;
    logic          irq_en = 1'b1;
    logic [NK-1:0] evt_clr = '0;
    logic [NK-1:0] key_state;
    logic [NK-1:0] press_evt;
    logic [NK-1:0] release_evt;
    logic [NK-1:0] long_evt;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    key_event_capture #(
        .NUM_KEYS(NK), .KEY_ACTIVE_LOW(1'b1), .DB_SAMPLES(DB), .LONG_TICKS(LT)
    ) dut (
        .clk(clk), .RSTn(rstn), .key_in(key_in), .debounce_period(debounce_period),
        .irq_en(irq_en), .evt_clr(evt_clr), .key_state(key_state), .press_evt(press_evt),
        .release_evt(release_evt), .long_evt(long_evt), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: pressed-level samples reach the debouncer two clocks late; a level
    // change is accepted after DB consecutive disagreeing tick samples.
    logic [NK-1:0] m_state, m_press, m_rel, m_long;
    logic          m_irq;
    logic [NK-1:0] m_pipe[$];
    logic [31:0]   m_tcnt;
    int            m_run[NK];
    int            m_held[NK];

    always @(posedge clk) begin : model
        logic [NK-1:0] samp;
        logic          tick;
        if (!rstn) begin
            m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_irq = 1'b0;
            m_tcnt = 32'd0;
            m_pipe.delete();
            m_pipe.push_back('0);
            m_pipe.push_back('0);
            for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_held[i] = 0; end
        end else begin
            samp = m_pipe.pop_front();
            m_pipe.push_back(~key_in);
            tick   = (m_tcnt >= debounce_period);
            m_tcnt = tick ? 32'd0 : m_tcnt + 32'd1;
            m_irq  = irq_en && ((m_press | m_rel | m_long) != '0);
            m_press = m_press & ~evt_clr;
            m_rel   = m_rel & ~evt_clr;
            m_long  = m_long & ~evt_clr;
            for (int i = 0; i < NK; i++) begin
                if (LONG_EN) begin
                    if (!m_state[i]) m_held[i] = 0;
                    else if (tick && m_held[i] < LT) begin
                        m_held[i]++;
                        if (m_held[i] == LT) m_long[i] = 1'b1;
                    end
                end
                if (tick) begin
                    if (samp[i] != m_state[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_run[i]   = 0;
                            m_state[i] = ~m_state[i];
                            if (m_state[i]) m_press[i] = 1'b1;
                            else            m_rel[i]   = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    end

    logic [4*NK:0] dut_obs;
    logic [4*NK:0] mdl_obs;
    assign dut_obs = {key_state, press_evt, release_evt, long_evt, irq};
    assign mdl_obs = {m_state, m_press, m_rel, m_long, m_irq};

    task automatic test_reset();
        rstn = 1'b0; key_in = '1; debounce_period = 32'd0; irq_en = 1'b1; evt_clr = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_tests++;
            if (dut_obs !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d got %h expected 0", c, dut_obs);
            end
        end
        $display("[TB] test_reset: idle 100 clocks after reset");
    endtask

    task automatic test_clean_press();
        key_in[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            n_tests++;
            if ({key_state[0], press_evt[0], irq} !== {1'(e >= 6), 1'(e >= 6), 1'(e >= 7)}) begin
                n_fail++;
                $display("FAIL clean_press edge %0d got state/press/irq %b%b%b", e, key_state[0], press_evt[0], irq);
            end
        end
        evt_clr = 4'b0001;
        @(negedge clk);
        evt_clr = '0;
        n_tests++;
        if ({press_evt[0], irq, key_state[0]} !== 3'b011) begin
            n_fail++;
            $display("FAIL clear_press got press/irq/state %b%b%b expected 011", press_evt[0], irq, key_state[0]);
        end
        @(negedge clk);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_irq got %b expected 0", irq);
        end
        $display("[TB] test_clean_press: key0 pressed at edge 6, irq at edge 7, cleared");
    endtask

    task automatic test_bounce();
        debounce_period = 32'd9;
        key_in[1] = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            @(negedge clk);
            if (e == 25) key_in[1] = 1'b1;
            if (e == 30) key_in[1] = 1'b0;
            n_tests++;
            if (dut_obs !== mdl_obs) begin
                n_fail++;
                $display("FAIL bounce_model edge %0d got %h expected %h", e, dut_obs, mdl_obs);
            end
            if (e == 69 || e == 70) begin
                n_tests++;
                if (press_evt[1] !== 1'(e == 70)) begin
                    n_fail++;
                    $display("FAIL bounce_press edge %0d got %b expected %b", e, press_evt[1], e == 70);
                end
            end
        end
        $display("[TB] test_bounce: glitch rejected, key1 accepted at edge 70");
    endtask

    task automatic test_collision();
        debounce_period = 32'd0;
        key_in[3:2] = 2'b00;
        repeat (8) @(negedge clk);
        evt_clr = '1;
        @(negedge clk);
        evt_clr = '0;
        repeat (2) @(negedge clk);
        key_in[3:2] = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            evt_clr = (e == 5) ? 4'b0100 : 4'b0000;
            n_tests++;
            if (dut_obs !== mdl_obs) begin
                n_fail++;
                $display("FAIL collision_model edge %0d got %h expected %h", e, dut_obs, mdl_obs);
            end
            if (e == 5 || e == 6) begin
                n_tests++;
                if (release_evt[3:2] !== ((e == 6) ? 2'b11 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL collision_release edge %0d got %b", e, release_evt[3:2]);
                end
            end
        end
        $display("[TB] test_collision: keys 2,3 released together, set beat clear");
    endtask

    task automatic test_period_change();
        debounce_period = 32'd1000;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            n_tests++;
            if (dut_obs !== mdl_obs) begin
                n_fail++;
                $display("FAIL period_idle cycle %0d got %h expected %h", c, dut_obs, mdl_obs);
            end
        end
        debounce_period = 32'd100;
        key_in[3] = 1'b0;
        for (int p = 1; p <= 410; p++) begin
            @(negedge clk);
            n_tests++;
            if (dut_obs !== mdl_obs) begin
                n_fail++;
                $display("FAIL period_model edge %0d got %h expected %h", p, dut_obs, mdl_obs);
            end
            if (p == 303 || p == 304) begin
                n_tests++;
                if (key_state[0] !== 1'(p == 304)) begin
                    n_fail++;
                    $display("FAIL period_key0 edge %0d got %b", p, key_state[0]);
                end
            end
            if (p == 404 || p == 405) begin
                n_tests++;
                if (key_state[3] !== 1'(p == 405)) begin
                    n_fail++;
                    $display("FAIL period_key3 edge %0d got %b", p, key_state[3]);
                end
            end
        end
        $display("[TB] test_period_change: 1000 -> 100 took effect on next clock");
    endtask

    task automatic test_reset_mid();
        debounce_period = 32'd0;
        evt_clr = '1;
        @(negedge clk);
        evt_clr = '0;
        key_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_tests++;
        if (dut_obs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear got %h expected 0", dut_obs);
        end
        for (int r = 1; r <= 6; r++) begin
            @(negedge clk);
            n_tests++;
            if ({key_state, press_evt} !== ((r == 6) ? 8'hFF : 8'h00)) begin
                n_fail++;
                $display("FAIL reset_mid_restart edge %0d got %h", r, {key_state, press_evt});
            end
        end
        $display("[TB] test_reset_mid: partial count discarded, restart from zero");
    endtask

    task automatic test_long();
        debounce_period = 32'd0;
        key_in = '1;
        repeat (8) @(negedge clk);
        evt_clr = '1;
        @(negedge clk);
        evt_clr = '0;
        repeat (2) @(negedge clk);
        key_in[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            evt_clr = (e == 12) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (dut_obs !== mdl_obs) begin
                n_fail++;
                $display("FAIL long_model edge %0d got %h expected %h", e, dut_obs, mdl_obs);
            end
            if (e == 10 || e == 11 || e == 20) begin
                n_tests++;
                if (long_evt[0] !== (LONG_EN && e == 11)) begin
                    n_fail++;
                    $display("FAIL long_evt edge %0d got %b expected %b", e, long_evt[0], LONG_EN && e == 11);
                end
            end
        end
        key_in[0] = 1'b1;
        repeat (7) @(negedge clk);
        n_tests++;
        if (release_evt[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL long_release got %b expected 1", release_evt[0]);
        end
        $display("[TB] test_long: long_evt once=%0d, release still reported", LONG_EN);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_tests++;
            if (dut_obs !== mdl_obs) begin
                n_fail++;
                $display("FAIL random_model cycle %0d got %h expected %h", c, dut_obs, mdl_obs);
            end
            rstn = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 5) == 0) key_in[$urandom_range(0, NK - 1)] ^= 1'b1;
            evt_clr = ($urandom_range(0, 7) == 0) ? NK'($urandom) : '0;
            if ($urandom_range(0, 49) == 0) irq_en = ~irq_en;
            if ($urandom_range(0, 99) == 0) debounce_period = 32'($urandom_range(0, 3));
        end
        rstn = 1'b1;
        $display("[TB] test_random: 1500 cycles of random keys, clears and periods");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_collision();
        test_period_change();
        test_reset_mid();
        test_long();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
